// File: rtl/bound_flasher_seq_pkg.sv
// Shared types and default geometry for the lamp-bar flasher sequencer.
package bf_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        UP_FULL   = 3'd1,
        DOWN_KP1  = 3'd2,
        UP_KP2    = 3'd3,
        DOWN_ZERO = 3'd4,
        UP_FULL2  = 3'd5,
        DOWN_END  = 3'd6
    } state_t;

    localparam int LAMPS_DEF = 16;
    localparam int KP1_DEF   = 5;
    localparam int KP2_DEF   = 10;

endpackage

// File: rtl/bound_flasher_seq_if.sv
// Request/status bundle between the flasher sequencer and the lamp output stage.
interface bound_flasher_seq_if #(
    parameter int LAMPS = bf_pkg::LAMPS_DEF
);
    import bf_pkg::*;

    logic             flick;
    logic [LAMPS-1:0] lamps;
    state_t           main_state;
    logic             busy;
    logic             done;

    modport master (output flick, input lamps, main_state, busy, done);
    modport slave  (input flick, output lamps, main_state, busy, done);
endinterface

// File: rtl/bound_flasher_seq_prescaler.sv
// Step prescaler: emits one tick every STEP_DIV clocks while run is high,
// and is held at zero while run is low.
module bf_step_prescaler #(
    parameter int STEP_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);
    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(STEP_DIV - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    always_comb begin
        tick  = run && (cnt_q == LAST);
        cnt_d = cnt_q + PW'(1);
        if (!run || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/bound_flasher_seq.sv
// Lamp-bar flasher sequencer: main FSM, lamp counter and thermometer lamp decode.
// Define BF_FLICK_SYNC_EN to pass flick through a 2-flop synchronizer first.
module bound_flasher_seq #(
    parameter int LAMPS    = bf_pkg::LAMPS_DEF,
    parameter int KP1      = bf_pkg::KP1_DEF,
    parameter int KP2      = bf_pkg::KP2_DEF,
    parameter int STEP_DIV = 1
) (
    input  logic               clk,
    input  logic               rst,
    bound_flasher_seq_if.slave bus
);
    import bf_pkg::*;

    localparam int CW = $clog2(LAMPS + 1);
    localparam logic [CW-1:0] LAMPS_C = CW'(LAMPS);
    localparam logic [CW-1:0] KP1_C   = CW'(KP1);
    localparam logic [CW-1:0] KP2_C   = CW'(KP2);

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             done_q, done_d;
    logic [CW-1:0]    n_up, n_dn;
    logic             tick;
    logic             flick_s;
    logic [LAMPS-1:0] lamps_dec;
    logic             busy_dec;

`ifdef BF_FLICK_SYNC_EN
    logic [1:0] flick_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flick_sync_q <= '0;
        end else begin
            flick_sync_q <= {flick_sync_q[0], bus.flick};
        end
    end

    assign flick_s = flick_sync_q[1];
`else
    assign flick_s = bus.flick;
`endif

    bf_step_prescaler #(
        .STEP_DIV (STEP_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .run  (busy_dec),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // Out-of-range counts fall back to IDLE instead of wrapping.
    always_comb begin
        n_up    = count_q + CW'(1);
        n_dn    = count_q - CW'(1);
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                count_d = '0;
                if (flick_s) begin
                    state_d = UP_FULL;
                end
            end
            UP_FULL, UP_KP2, UP_FULL2: begin
                if (tick) begin
                    if (count_q >= LAMPS_C) begin
                        state_d = IDLE;
                        count_d = '0;
                    end else begin
                        count_d = n_up;
                        if (state_q == UP_FULL) begin
                            if (n_up == LAMPS_C) state_d = DOWN_KP1;
                        end else if (state_q == UP_KP2) begin
                            if (n_up == KP2_C) state_d = flick_s ? DOWN_KP1 : DOWN_ZERO;
                        end else if (flick_s && (n_up == KP1_C || n_up == KP2_C)) begin
                            state_d = DOWN_ZERO;
                        end else if (n_up == LAMPS_C) begin
                            state_d = DOWN_END;
                        end
                    end
                end
            end
            DOWN_KP1, DOWN_ZERO, DOWN_END: begin
                if (tick) begin
                    if (count_q == '0) begin
                        state_d = IDLE;
                        count_d = '0;
                    end else begin
                        count_d = n_dn;
                        if (state_q == DOWN_KP1) begin
                            if (n_dn == KP1_C) state_d = UP_KP2;
                        end else if (state_q == DOWN_ZERO) begin
                            if (n_dn == '0) state_d = UP_FULL2;
                        end else if (n_dn == '0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_comb begin
        lamps_dec = '0;
        for (int i = 0; i < LAMPS; i++) begin
            lamps_dec[i] = (i < int'(count_q));
        end
        busy_dec = (state_q != IDLE);
    end

    assign bus.lamps      = lamps_dec;
    assign bus.main_state = state_q;
    assign bus.busy       = busy_dec;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_bound_flasher_seq.sv
// Directed bench for bound_flasher_seq: full run, kickbacks, mid-run reset, slow stepping.
module tb_bound_flasher_seq;
    import bf_pkg::*;

`ifdef BF_FLICK_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    bound_flasher_seq_if #(.LAMPS(16)) bus1 ();
    bound_flasher_seq_if #(.LAMPS(16)) bus3 ();

    bound_flasher_seq #(.LAMPS(16), .KP1(5), .KP2(10), .STEP_DIV(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    bound_flasher_seq #(.LAMPS(16), .KP1(5), .KP2(10), .STEP_DIV(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    task automatic run_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus1.flick = 1'b0;
        bus3.flick = 1'b0;
        rst = 1'b1;
        run_edge();
        run_edge();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus1.flick = 1'b0;
        bus3.flick = 1'b0;
        rst = 1'b1;
        run_edge();
        checks++;
        if (bus1.main_state !== IDLE || bus1.lamps !== 16'h0000 || bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin
            failures++;
            $display("FAIL reset: state=%0d lamps=%h busy=%b done=%b, expected 0 0000 0 0",
                     bus1.main_state, bus1.lamps, bus1.busy, bus1.done);
        end
        checks++;
        if (bus3.main_state !== IDLE || bus3.lamps !== 16'h0000) begin
            failures++;
            $display("FAIL reset_div3: state=%0d lamps=%h, expected 0 0000", bus3.main_state, bus3.lamps);
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) run_edge();
        checks++;
        if (bus1.main_state !== IDLE || bus1.busy !== 1'b0 || bus1.lamps !== 16'h0000) begin
            failures++;
            $display("FAIL idle_no_flick: state=%0d busy=%b lamps=%h, expected 0 0 0000",
                     bus1.main_state, bus1.busy, bus1.lamps);
        end
    endtask

    task automatic test_full_run();
        int          ek[9] = '{1, 17, 28, 33, 43, 59, 74, 75, 76};
        logic [2:0]  es[9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6, 3'd0, 3'd0};
        logic [15:0] el[9] = '{16'h0000, 16'hFFFF, 16'h001F, 16'h03FF, 16'h0000,
                               16'hFFFF, 16'h0001, 16'h0000, 16'h0000};
        logic        ed[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0]  ev[7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
        logic [2:0]  vis[8];
        logic [2:0]  last_st;
        int          nvis;
        int          ndone;
        int          vbad;
        do_reset();
        last_st = IDLE;
        nvis    = 0;
        ndone   = 0;
        for (int j = 0; j < 8; j++) vis[j] = 3'd7;
        bus1.flick = 1'b1;
        for (int k = 1; k <= 80 + SYNC; k++) begin
            run_edge();
            if (k == 1) bus1.flick = 1'b0;
            if (bus1.done === 1'b1) ndone++;
            if (bus1.main_state !== last_st) begin
                if (nvis < 8) vis[nvis] = bus1.main_state;
                nvis++;
                last_st = bus1.main_state;
            end
            for (int j = 0; j < 9; j++) begin
                if (k == ek[j] + SYNC) begin
                    checks++;
                    if (bus1.main_state !== es[j] || bus1.lamps !== el[j] || bus1.done !== ed[j]) begin
                        failures++;
                        $display("FAIL full_run k=%0d: state=%0d lamps=%h done=%b, expected state=%0d lamps=%h done=%b",
                                 k, bus1.main_state, bus1.lamps, bus1.done, es[j], el[j], ed[j]);
                    end
                end
            end
        end
        checks++;
        if (ndone != 1) begin
            failures++;
            $display("FAIL full_run_done_count: got %0d pulses, expected 1", ndone);
        end
        vbad = (nvis != 7) ? 1 : 0;
        for (int j = 0; j < 7; j++) if (vis[j] !== ev[j]) vbad = 1;
        checks++;
        if (vbad != 0) begin
            failures++;
            $display("FAIL full_run_order: %0d states seen, first %0d %0d %0d %0d %0d %0d %0d, expected 7: 1 2 3 4 5 6 0",
                     nvis, vis[0], vis[1], vis[2], vis[3], vis[4], vis[5], vis[6]);
        end
    endtask

    task automatic test_hold_flick();
        int          ek[9] = '{33, 34, 38, 43, 53, 63, 79, 95, 96};
        logic [2:0]  es[9] = '{3'd2, 3'd2, 3'd3, 3'd2, 3'd4, 3'd5, 3'd6, 3'd0, 3'd0};
        logic [15:0] el[9] = '{16'h03FF, 16'h01FF, 16'h001F, 16'h03FF, 16'h03FF,
                               16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
        logic        ed[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        bus1.flick = 1'b1;
        for (int k = 1; k <= 96 + SYNC; k++) begin
            run_edge();
            if (k == 43) bus1.flick = 1'b0;
            for (int j = 0; j < 9; j++) begin
                if (k == ek[j] + SYNC) begin
                    checks++;
                    if (bus1.main_state !== es[j] || bus1.lamps !== el[j] || bus1.done !== ed[j]) begin
                        failures++;
                        $display("FAIL hold_flick k=%0d: state=%0d lamps=%h done=%b, expected state=%0d lamps=%h done=%b",
                                 k, bus1.main_state, bus1.lamps, bus1.done, es[j], el[j], ed[j]);
                    end
                end
            end
        end
    endtask

    task automatic test_kick_full2();
        int          ek[7] = '{47, 48, 49, 53, 69, 85, 86};
        logic [2:0]  es[7] = '{3'd5, 3'd4, 3'd4, 3'd5, 3'd6, 3'd0, 3'd0};
        logic [15:0] el[7] = '{16'h000F, 16'h001F, 16'h000F, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
        logic        ed[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        bus1.flick = 1'b1;
        for (int k = 1; k <= 86 + SYNC; k++) begin
            run_edge();
            if (k == 1)  bus1.flick = 1'b0;
            if (k == 47) bus1.flick = 1'b1;
            if (k == 48) bus1.flick = 1'b0;
            for (int j = 0; j < 7; j++) begin
                if (k == ek[j] + SYNC) begin
                    checks++;
                    if (bus1.main_state !== es[j] || bus1.lamps !== el[j] || bus1.done !== ed[j]) begin
                        failures++;
                        $display("FAIL kick_full2 k=%0d: state=%0d lamps=%h done=%b, expected state=%0d lamps=%h done=%b",
                                 k, bus1.main_state, bus1.lamps, bus1.done, es[j], el[j], ed[j]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int ndone;
        do_reset();
        bus1.flick = 1'b1;
        for (int k = 1; k <= 21 + SYNC; k++) begin
            run_edge();
            if (k == 1) bus1.flick = 1'b0;
        end
        checks++;
        if (bus1.main_state !== DOWN_KP1 || bus1.lamps !== 16'h0FFF) begin
            failures++;
            $display("FAIL mid_run_setup: state=%0d lamps=%h, expected 2 0fff", bus1.main_state, bus1.lamps);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus1.main_state !== IDLE || bus1.lamps !== 16'h0000 || bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin
            failures++;
            $display("FAIL mid_run_abort: state=%0d lamps=%h busy=%b done=%b, expected 0 0000 0 0",
                     bus1.main_state, bus1.lamps, bus1.busy, bus1.done);
        end
        run_edge();
        rst   = 1'b0;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            run_edge();
            if (bus1.done === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0 || bus1.main_state !== IDLE) begin
            failures++;
            $display("FAIL mid_run_no_done: pulses=%0d state=%0d, expected 0 pulses state 0", ndone, bus1.main_state);
        end
        bus1.flick = 1'b1;
        for (int k = 1; k <= 5 + SYNC; k++) begin
            run_edge();
            if (k == 1) bus1.flick = 1'b0;
            if (k == 1 + SYNC) begin
                checks++;
                if (bus1.main_state !== UP_FULL || bus1.lamps !== 16'h0000) begin
                    failures++;
                    $display("FAIL restart_start: state=%0d lamps=%h, expected 1 0000", bus1.main_state, bus1.lamps);
                end
            end
            if (k == 5 + SYNC) begin
                checks++;
                if (bus1.main_state !== UP_FULL || bus1.lamps !== 16'h000F) begin
                    failures++;
                    $display("FAIL restart_count: state=%0d lamps=%h, expected 1 000f", bus1.main_state, bus1.lamps);
                end
            end
        end
    endtask

    task automatic test_step_div3();
        int          ek[10] = '{1, 2, 3, 4, 6, 7, 10, 222, 223, 224};
        logic [2:0]  es[10] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd6, 3'd0, 3'd0};
        logic [15:0] el[10] = '{16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0001,
                                16'h0003, 16'h0007, 16'h0001, 16'h0000, 16'h0000};
        logic        ed[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        bus3.flick = 1'b1;
        for (int k = 1; k <= 224 + SYNC; k++) begin
            run_edge();
            if (k == 1) bus3.flick = 1'b0;
            for (int j = 0; j < 10; j++) begin
                if (k == ek[j] + SYNC) begin
                    checks++;
                    if (bus3.main_state !== es[j] || bus3.lamps !== el[j] || bus3.done !== ed[j]) begin
                        failures++;
                        $display("FAIL step_div3 k=%0d: state=%0d lamps=%h done=%b, expected state=%0d lamps=%h done=%b",
                                 k, bus3.main_state, bus3.lamps, bus3.done, es[j], el[j], ed[j]);
                    end
                end
            end
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        bus1.flick = 1'b0;
        bus3.flick = 1'b0;
        test_reset();
        test_full_run();
        test_hold_flick();
        test_kick_full2();
        test_reset_mid_run();
        test_step_div3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bound_flasher_seq.md
Name: bound_flasher_seq

Overview:
- Sequential controller for the lamp-bar flasher. Owns the registered main state, the lamp counter and the step prescaler.
- Sequences the lamp bar through the fixed up/down pattern on a flick request, with kickback at the kick points.
- Drives the thermometer-coded lamp vector to the lamp output stage and exposes state and status to the top level.

Parameters:
- LAMPS, 16, number of lamps; count range 0..LAMPS; CW = $clog2(LAMPS+1).
- KP1, 5, first kick point / lower bounce target; must satisfy 0 < KP1 < KP2.
- KP2, 10, second kick point / upper bounce target; must satisfy KP2 < LAMPS.
- STEP_DIV, 1, clocks per lamp step; minimum 1 (1 = step every clock).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- flick  in  1  level request / kickback qualifier.
- lamps  out  LAMPS  lamps[i]=1 iff i < count (thermometer code).
- main_state  out  3  current state encoding (bf_pkg::state_t).
- busy  out  1  1 whenever main_state != IDLE.
- done  out  1  one-clock pulse on the return to IDLE.

Behaviour:
- Reset (async, rst=1): main_state=IDLE, count=0, lamps=0, busy=0, done=0, prescaler=0. Reset mid-sequence aborts immediately, with no completion pulse.
- States: IDLE=0, UP_FULL=1, DOWN_KP1=2, UP_KP2=3, DOWN_ZERO=4, UP_FULL2=5, DOWN_END=6. Encoding 7 is unused and recovers to IDLE with count=0 on the next edge.
- IDLE:
  - Prescaler is held at 0.
  - If flick=1 at a rising edge, next state is UP_FULL; count stays 0.
- Prescaler:
  - Runs in all non-IDLE states, counting 0..STEP_DIV-1.
  - tick=1 when the prescaler equals STEP_DIV-1; the prescaler wraps to 0 on tick.
  - State and count change only on tick edges, except the IDLE exit.
- UP states, on tick: count <= count+1. With n = count+1:
  - UP_FULL: n==LAMPS -> DOWN_KP1.
  - UP_KP2: n==KP2 -> DOWN_KP1 if flick=1 (kickback), else DOWN_ZERO.
  - UP_FULL2:
    - n==KP1 or n==KP2, and flick=1 -> DOWN_ZERO (kickback).
    - n==LAMPS -> DOWN_END.
  - Kickback takes priority over the normal target transition.
- DOWN states, on tick: count <= count-1. With n = count-1:
  - DOWN_KP1: n==KP1 -> UP_KP2.
  - DOWN_ZERO: n==0 -> UP_FULL2.
  - DOWN_END: n==0 -> IDLE, and done=1 for exactly the following cycle.
- flick is ignored in every state except IDLE and the kick-point ticks. Holding flick=1 in IDLE after done restarts the sequence on the next edge.
- Count never leaves 0..LAMPS; no wrap. A saturate guard forces IDLE if count would underflow or overflow (unreachable when the parameters are legal).
- Outputs are registered or decoded from registers only; none is combinational from flick.
- Latency:
  - flick to first lamp = 1 + STEP_DIV clocks.
  - Full un-kicked run = 1 + 74*STEP_DIV clocks for LAMPS=16 (16+11+5+10+16+16 steps).

Optional Feature:
- Macro BF_FLICK_SYNC_EN.
- Defined: flick passes through a 2-flop synchronizer, reset to 0, and all flick decisions use the synchronized copy. All flick-related latencies grow by 2 clocks.
- Undefined: flick is used directly, and the input must be synchronous to clk.

Decomposition:
- bf_pkg holds:
  - typedef enum logic [2:0] state_t with the seven state names above;
  - localparam defaults for LAMPS, KP1, KP2.
- One sub-module: bf_step_prescaler, with ports clk, rst, run, tick and parameter STEP_DIV.
- The state/count update is a single always_ff with a combinational next-state block in the top.

Test Plan (LAMPS=16, KP1=5, KP2=10, STEP_DIV=1, macro undefined):
- flick=1 for 1 cycle then 0 -> states 1,2,3,4,5,6,0 visited in order; lamps 0->0xFFFF->0x001F->0x03FF->0->0xFFFF->0; done pulses once, 75 clocks after the flick edge.
- flick held 1 throughout -> at UP_KP2 count 10, returns to DOWN_KP1 (count 9 next step). The 5<->10 bounce repeats until flick drops; on release the sequence completes normally.
- flick=1 only on the edge where count reaches 5 in UP_FULL2 -> DOWN_ZERO, count 4 next step; sequence then continues to UP_FULL2 again.
- rst asserted while in DOWN_KP1 with count=12 -> immediately IDLE, lamps=0, done never pulses; flick afterwards restarts cleanly.
- STEP_DIV=3: the count changes exactly every 3rd clock; the first lamp appears 4 clocks after flick.
- With BF_FLICK_SYNC_EN defined: the same first scenario, with every flick-to-response latency +2 clocks.
